dz_scan: RTL and testbench
==========================

# dz_scan

8×8 bicolour dot-matrix scan driver: the display-side consumer of the image index produced by the egg-hatch transfer stage. It accepts a 4-bit image index with a load strobe and a fail flag, and holds them in a pending slot. It swaps them in only at frame boundaries so a frame never tears. It then row-multiplexes the selected bitmap onto the red or green column plane, with a short column blanking window at each row change to suppress ghosting.

## Interface
- SCAN_DIV, 1000: clock cycles per row slot; legal range ≥ 2.
- BLANK_CYC, 2: cycles at the start of each row slot during which all columns are forced off; legal range 0 ≤ BLANK_CYC < SCAN_DIV.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- img_ld  in  1  one-cycle strobe: capture img_idx and fail into the pending slot.
- img_idx  in  4  image number. 0–7 are egg growth stages, 8–11 are animals, 12–13 are artwork, 14 is all-on lamp test, 15 is blank.
- fail  in  1  colour select captured with img_ld: 0 drives the red plane, 1 drives the green plane.
- row  out  8  row select, active-low, one-hot-low while running.
- colr  out  8  red column data, active-high.
- colg  out  8  green column data, active-high.
- frame_done  out  1  one-cycle pulse when the frame boundary swap occurs.

## Operation
- ROM: 16 images × 8 rows × 8 bits, combinational, indexed by {act_img, row_idx}. Image 14 has every row = 8'hFF. Image 15 has every row = 8'h00. Images 0–13 come from the team artwork table.
- Prescaler pc counts 0..SCAN_DIV-1 and wraps. A row tick is the cycle with pc == SCAN_DIV-1.
- On a row tick, row_idx (3 bits) increments and wraps 7 → 0.
- Frame boundary is a row tick while row_idx == 7.
- Pending slot: pend_img, pend_fail, and pend_v.
  - img_ld = 1 writes img_idx and fail into the slot and sets pend_v.
  - Multiple loads within one frame: the last load wins.
- At a frame boundary with pend_v = 1: act_img ← pend_img, act_fail ← pend_fail, pend_v ← 0.
- At a frame boundary with pend_v = 0: the active values are held.
- img_ld on the same cycle as a frame boundary bypasses the slot: the incoming img_idx and fail become active directly, and pend_v ends at 0.
- img_ld is never ignored.
- Output function f, evaluated on the current state:
  - row = ~(8'b1 << row_idx).
  - d = ROM[act_img][row_idx], or 8'h00 if pc < BLANK_CYC.
  - colr = act_fail ? 0 : d.
  - colg = act_fail ? d : 0.
- frame_done = 1 exactly on the cycle after a frame boundary tick (registered), regardless of pend_v.
- States are implicit (pc, row_idx). There is no idle state: scanning runs continuously from reset release.

## Timing
- Reset values, asynchronous on rst_n = 0:
  - pc = 0, row_idx = 0, act_img = 15, act_fail = 0, pend_v = 0.
  - row = 8'hFF, colr = 8'h00, colg = 8'h00, frame_done = 0.
- Reset asserted mid-frame clears everything immediately; a pending load is lost.
- Outputs are registered: on each edge they take f() of the state before that edge, giving one cycle of latency.
- The first edge after reset release drives row = 8'hFE.
- Each row is visible for exactly SCAN_DIV cycles. A frame is 8·SCAN_DIV cycles.
- Load-to-display latency: from the img_ld edge to the first row-0 output of the new image is at most 8·SCAN_DIV + 1 cycles. It is exactly 1 cycle after the boundary when img_ld coincides with the boundary.
- BLANK_CYC = 0 disables blanking.
- Arithmetic rules:
  - pc width is $clog2(SCAN_DIV).
  - row_idx wraps modulo 8.
  - There is no overflow on any counter.

## Test plan
- Reset/idle, SCAN_DIV=4, BLANK_CYC=1:
  - Hold rst_n low → row=FF, colr=colg=00.
  - Release → row steps FE, FD, … 7F every 4 cycles.
  - Columns stay 00 (image 15).
  - frame_done pulses every 32 cycles.
- Lamp test:
  - img_ld with img_idx=14, fail=0 mid-frame → no column change until after the boundary.
  - Then colr=FF in cycles 2–4 of each row slot and 00 in cycle 1.
  - colg=00 throughout.
- Fail colour:
  - Load 14 with fail=1 → after the boundary colg=FF (outside blanking) and colr=00 on every row.
- Last-wins:
  - Load 14, then load 15 within the same frame → after the boundary, columns are all 00.
  - There is no single-frame flash of 14.
- Boundary coincidence:
  - img_ld=14 exactly on the pc=3, row_idx=7 cycle → the next output has row=FE, col blanked.
  - The following cycle shows colr=FF.
- Reset mid-operation:
  - Pending load of 14 issued, then rst_n pulsed low before the boundary → outputs return to FF/00/00.
  - Image 15 stays active: the load is dropped.

Source files
------------

// File: rtl/dz_scan.sv
// ============================================================================
// Module   : dz_scan
// Brief    : 8x8 bicolour dot-matrix row-scan driver with frame-synchronous
//            image swap and per-row column blanking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dz_scan #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       img_ld,
  input  logic [3:0] img_idx,
  input  logic       fail,
  output logic [7:0] row,
  output logic [7:0] colr,
  output logic [7:0] colg,
  output logic       frame_done
);

  localparam int             PCW     = $clog2(SCAN_DIV);
  localparam logic [PCW-1:0] PC_LAST = PCW'(SCAN_DIV - 1);
  localparam logic [3:0]     IMG_OFF = 4'd15;

  // Bitmap store; byte n of each 64-bit word is row n, bit n is column n.
  function automatic logic [7:0] rom_row(input logic [3:0] img, input logic [2:0] r);
    logic [63:0] bm;
    bm = 64'h0;
    case (img)
      4'd0:  bm = 64'h0000_0018_1800_0000;
      4'd1:  bm = 64'h0000_1824_2418_0000;
      4'd2:  bm = 64'h0018_2442_4224_1800;
      4'd3:  bm = 64'h0018_2452_4224_1800;
      4'd4:  bm = 64'h0018_2C52_4A34_1800;
      4'd5:  bm = 64'h003C_5A66_5A24_1800;
      4'd6:  bm = 64'h003C_4299_A542_2400;
      4'd7:  bm = 64'h0081_4224_1824_4281;
      4'd8:  bm = 64'h0066_FFFF_7E3C_1800;
      4'd9:  bm = 64'h0024_7EDB_FF7E_2442;
      4'd10: bm = 64'h0814_2241_7F41_4100;
      4'd11: bm = 64'h3C42_A581_A599_423C;
      4'd12: bm = 64'hAA55_AA55_AA55_AA55;
      4'd13: bm = 64'h8142_2418_1824_4281;
      4'd14: bm = 64'hFFFF_FFFF_FFFF_FFFF;
      default: bm = 64'h0;
    endcase
    return bm[{r, 3'b000} +: 8];
  endfunction

  logic [PCW-1:0] pc_q,        pc_d;
  logic [2:0]     row_idx_q,   row_idx_d;
  logic [3:0]     act_img_q,   act_img_d;
  logic           act_fail_q,  act_fail_d;
  logic [3:0]     pend_img_q,  pend_img_d;
  logic           pend_fail_q, pend_fail_d;
  logic           pend_v_q,    pend_v_d;
  logic [7:0]     row_q,       row_d;
  logic [7:0]     colr_q,      colr_d;
  logic [7:0]     colg_q,      colg_d;
  logic           frame_done_q, frame_done_d;

  logic           w_tick;
  logic           w_bnd;
  logic           w_blank;
  logic [7:0]     w_dots;

  generate
    if (BLANK_CYC > 0) begin : g_blank
      assign w_blank = (pc_q < PCW'(BLANK_CYC));
    end else begin : g_noblank
      assign w_blank = 1'b0;
    end
  endgenerate

  assign w_tick = (pc_q == PC_LAST);
  assign w_bnd  = w_tick && (row_idx_q == 3'd7);
  assign w_dots = w_blank ? 8'h00 : rom_row(act_img_q, row_idx_q);

  always_comb begin
    pc_d         = w_tick ? '0 : pc_q + 1'b1;
    row_idx_d    = w_tick ? row_idx_q + 3'd1 : row_idx_q;
    act_img_d    = act_img_q;
    act_fail_d   = act_fail_q;
    pend_img_d   = pend_img_q;
    pend_fail_d  = pend_fail_q;
    pend_v_d     = pend_v_q;

    // A load landing on the boundary goes straight to the active image.
    if (img_ld) begin
      if (w_bnd) begin
        act_img_d  = img_idx;
        act_fail_d = fail;
        pend_v_d   = 1'b0;
      end else begin
        pend_img_d  = img_idx;
        pend_fail_d = fail;
        pend_v_d    = 1'b1;
      end
    end else if (w_bnd && pend_v_q) begin
      act_img_d  = pend_img_q;
      act_fail_d = pend_fail_q;
      pend_v_d   = 1'b0;
    end

    row_d        = ~(8'd1 << row_idx_q);
    colr_d       = act_fail_q ? 8'h00 : w_dots;
    colg_d       = act_fail_q ? w_dots : 8'h00;
    frame_done_d = w_bnd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= '0;
      row_idx_q    <= 3'd0;
      act_img_q    <= IMG_OFF;
      act_fail_q   <= 1'b0;
      pend_img_q   <= 4'd0;
      pend_fail_q  <= 1'b0;
      pend_v_q     <= 1'b0;
      row_q        <= 8'hFF;
      colr_q       <= 8'h00;
      colg_q       <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      row_idx_q    <= row_idx_d;
      act_img_q    <= act_img_d;
      act_fail_q   <= act_fail_d;
      pend_img_q   <= pend_img_d;
      pend_fail_q  <= pend_fail_d;
      pend_v_q     <= pend_v_d;
      row_q        <= row_d;
      colr_q       <= colr_d;
      colg_q       <= colg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row        = row_q;
  assign colr       = colr_q;
  assign colg       = colg_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_dz_scan.sv
// ============================================================================
// Module   : tb_dz_scan
// Brief    : Self-checking bench for dz_scan against a frame-position model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dz_scan;

  localparam int SD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = 8 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       img_ld = 1'b0;
  logic [3:0] img_idx = 4'd0;
  logic       fail = 1'b0;
  logic [7:0] row, colr, colg;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  // Model state: cycles since reset release, plus active/pending image.
  int         t;
  logic [3:0] m_act, m_pend;
  logic       m_afail, m_pfail, m_pv;

  dz_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .img_ld(img_ld), .img_idx(img_idx), .fail(fail),
    .row(row), .colr(colr), .colg(colg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0; m_act = 4'd15; m_afail = 1'b0; m_pend = 4'd0; m_pfail = 1'b0; m_pv = 1'b0;
  endtask

  // One clock: outputs after the edge reflect the frame position before it.
  task automatic step(input logic ld, input logic [3:0] idx, input logic fl);
    int pos, r, p;
    logic bnd, known, blanked, sel_g;
    logic [7:0] e_row, d;
    pos = t % FRAME; r = pos / SD; p = pos % SD;
    bnd = (pos == FRAME - 1);
    e_row = ~(8'd1 << r);
    blanked = (p < BC);
    known = (m_act >= 4'd14);
    d = (blanked || m_act != 4'd14) ? 8'h00 : 8'hFF;
    sel_g = m_afail;
    img_ld = ld; img_idx = idx; fail = fl;
    @(posedge clk);
    if (ld && bnd) begin
      m_act = idx; m_afail = fl; m_pv = 1'b0;
    end else if (ld) begin
      m_pend = idx; m_pfail = fl; m_pv = 1'b1;
    end else if (bnd && m_pv) begin
      m_act = m_pend; m_afail = m_pfail; m_pv = 1'b0;
    end
    t++;
    #1;
    img_ld = 1'b0;
    check("row", row, e_row);
    check("frame_done", {7'd0, frame_done}, {7'd0, bnd});
    if (known || blanked) begin
      check("colr", colr, sel_g ? 8'h00 : d);
      check("colg", colg, sel_g ? d : 8'h00);
    end else if (sel_g) begin
      check("colr_off", colr, 8'h00);
    end else begin
      check("colg_off", colg, 8'h00);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0);
  endtask

  task automatic goto_pos(input int target);
    while ((t % FRAME) != target) step(1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    model_reset();
    // Reset held: outputs idle.
    repeat (3) @(posedge clk);
    #1;
    check("rst_row", row, 8'hFF);
    check("rst_colr", colr, 8'h00);
    check("rst_colg", colg, 8'h00);
    check("rst_fd", {7'd0, frame_done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Idle scan of blank image across two frames.
    run(2 * FRAME + 3);

    // Lamp test loaded mid-frame, red plane.
    goto_pos(10);
    step(1'b1, 4'd14, 1'b0);
    run(FRAME + 20);

    // Lamp test on the green plane.
    goto_pos(5);
    step(1'b1, 4'd14, 1'b1);
    run(FRAME + 10);

    // Last load in a frame wins.
    goto_pos(3);
    step(1'b1, 4'd14, 1'b0);
    run(5);
    step(1'b1, 4'd15, 1'b0);
    run(FRAME + 10);

    // Load coinciding with the frame boundary bypasses the slot.
    goto_pos(FRAME - 1);
    step(1'b1, 4'd14, 1'b0);
    run(10);

    // Reset mid-frame with a load pending drops the load.
    goto_pos(2);
    step(1'b1, 4'd15, 1'b1);
    goto_pos(FRAME - 1);
    step(1'b0, 4'd0, 1'b0);
    goto_pos(5);
    step(1'b1, 4'd14, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_row", row, 8'hFF);
    check("mid_rst_colr", colr, 8'h00);
    check("mid_rst_colg", colg, 8'h00);
    check("mid_rst_fd", {7'd0, frame_done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(FRAME + 12);

    // Randomised loads at arbitrary points, including boundaries.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0)
        step(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else
        step(1'b0, 4'd0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
